// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase sequencer and its shift-counter core.
package phase_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_JOHNSON = 1'b0;
   localparam logic MODE_RING    = 1'b1;
   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DN       = 1'b1;

   localparam int MAX_WIDTH = 16;

   // Johnson starts from all-zeros; ring needs exactly one hot bit to circulate.
   function automatic logic [MAX_WIDTH-1:0] seed(input logic mode, input int width);
      logic [MAX_WIDTH-1:0] s;
      s = '0;
      if (mode == MODE_RING && width > 0)
         s[0] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/shift_counter_core.sv
// WIDTH-bit Johnson/ring shift counter with synchronous load and advance.
module shift_counter_core
   import phase_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             adv,
   input  logic             mode,
   input  logic             dir,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] up_next;
   logic [WIDTH-1:0] dn_next;
   logic [WIDTH-1:0] q_next;

   // The bit that wraps around is inverted in Johnson mode, passed straight in ring mode.
   assign up_next[0]       = (mode == MODE_RING) ? q_reg[WIDTH-1] : ~q_reg[WIDTH-1];
   assign dn_next[WIDTH-1] = (mode == MODE_RING) ? q_reg[0]       : ~q_reg[0];

   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
         assign up_next[gi]   = q_reg[gi-1];
         assign dn_next[gi-1] = q_reg[gi];
      end
   endgenerate

   always_comb begin
      q_next = q_reg;
      if (load)
         q_next = seed;
      else if (adv)
         q_next = (dir == DIR_DN) ? dn_next : up_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q_reg <= '0;
      else
         q_reg <= q_next;
   end

   assign q = q_reg;

endmodule

// File: rtl/phase_seq_ctrl.sv
// Runs a shift counter for a programmed number of advances with busy/done handshake.
module phase_seq_ctrl
   import phase_seq_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic              dir,
   input  logic [STEP_W-1:0] steps,
   input  logic              hold,
   input  logic              abort,
   output logic [WIDTH-1:0]  q,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_cnt
);

   state_t            state_reg;
   state_t            state_next;
   logic              mode_reg;
   logic              dir_reg;
   logic [STEP_W-1:0] remaining_reg;
   logic [STEP_W-1:0] step_cnt_reg;

   logic              accept;
   logic              kill;
   logic              adv;
   logic              core_load;
   logic [WIDTH-1:0]  seed_val;
   logic [WIDTH-1:0]  core_seed;

   assign accept    = (state_reg == IDLE) && start;
   assign kill      = (state_reg == RUN) && abort;
   assign adv       = (state_reg == RUN) && !abort && !hold;
   assign seed_val  = WIDTH'(seed(mode, WIDTH));
   // Abort reuses the load path with an all-zero seed.
   assign core_load = accept || kill;
   assign core_seed = kill ? '0 : seed_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = (steps == '0) ? DONE : RUN;
         RUN: begin
            if (abort)
               state_next = IDLE;
            else if (!hold && remaining_reg == STEP_W'(1))
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_reg      <= MODE_JOHNSON;
         dir_reg       <= DIR_UP;
         remaining_reg <= '0;
         step_cnt_reg  <= '0;
      end else if (accept) begin
         mode_reg      <= mode;
         dir_reg       <= dir;
         remaining_reg <= steps;
         step_cnt_reg  <= '0;
      end else if (adv) begin
         remaining_reg <= remaining_reg - STEP_W'(1);
         step_cnt_reg  <= step_cnt_reg + STEP_W'(1);
      end
   end

   shift_counter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .load  (core_load),
      .seed  (core_seed),
      .adv   (adv),
      .mode  (mode_reg),
      .dir   (dir_reg),
      .q     (q)
   );

   assign step_cnt = step_cnt_reg;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed self-checking bench for phase_seq_ctrl (WIDTH=4, STEP_W=8).
module tb_phase_seq_ctrl;

   localparam int WIDTH  = 4;
   localparam int STEP_W = 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic              mode;
   logic              dir;
   logic [STEP_W-1:0] steps;
   logic              hold;
   logic              abort;
   logic [WIDTH-1:0]  q;
   logic              busy;
   logic              done;
   logic [STEP_W-1:0] step_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   phase_seq_ctrl #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .dir      (dir),
      .steps    (steps),
      .hold     (hold),
      .abort    (abort),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .step_cnt (step_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic m, input logic d, input logic [STEP_W-1:0] n);
      mode  = m;
      dir   = d;
      steps = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   logic [WIDTH-1:0] jup_exp [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
   logic [WIDTH-1:0] rdn_exp [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};

   initial begin
      reset = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      dir   = 1'b0;
      steps = '0;
      hold  = 1'b0;
      abort = 1'b0;
      tick();
      check("rst_q", 32'(q), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_stepcnt", 32'(step_cnt), 32'h0);
      reset = 1'b1;
      tick();

      // Johnson up, 5 steps
      launch(1'b0, 1'b0, 8'd5);
      check("jup_seed", 32'(q), 32'h0);
      check("jup_busy0", 32'(busy), 32'h1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("jup_q%0d", k + 1), 32'(q), 32'(jup_exp[k]));
         check($sformatf("jup_busy%0d", k + 1), 32'(busy), (k < 4) ? 32'h1 : 32'h0);
         check($sformatf("jup_done%0d", k + 1), 32'(done), (k == 4) ? 32'h1 : 32'h0);
      end
      tick();
      check("jup_done_clr", 32'(done), 32'h0);
      check("jup_stepcnt", 32'(step_cnt), 32'd5);
      check("jup_qhold", 32'(q), 32'he);

      // Ring down with wrap, 6 steps
      launch(1'b1, 1'b1, 8'd6);
      check("rdn_seed", 32'(q), 32'h1);
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("rdn_q%0d", k + 1), 32'(q), 32'(rdn_exp[k]));
         check($sformatf("rdn_done%0d", k + 1), 32'(done), (k == 5) ? 32'h1 : 32'h0);
      end
      tick();
      check("rdn_stepcnt", 32'(step_cnt), 32'd6);
      check("rdn_done_clr", 32'(done), 32'h0);

      // Zero steps in ring mode
      launch(1'b1, 1'b0, 8'd0);
      check("zero_q", 32'(q), 32'h1);
      check("zero_done", 32'(done), 32'h1);
      check("zero_busy", 32'(busy), 32'h0);
      tick();
      check("zero_done_clr", 32'(done), 32'h0);
      check("zero_busy_idle", 32'(busy), 32'h0);

      // Ring up, 3 steps, held for 2 cycles after the first advance
      launch(1'b1, 1'b0, 8'd3);
      check("hold_seed", 32'(q), 32'h1);
      tick();
      check("hold_q1", 32'(q), 32'h2);
      hold = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("hold_frz_q%0d", k), 32'(q), 32'h2);
         check($sformatf("hold_frz_cnt%0d", k), 32'(step_cnt), 32'd1);
         check($sformatf("hold_frz_busy%0d", k), 32'(busy), 32'h1);
      end
      hold = 1'b0;
      tick();
      check("hold_q2", 32'(q), 32'h4);
      check("hold_nodone", 32'(done), 32'h0);
      tick();
      check("hold_q3", 32'(q), 32'h8);
      check("hold_done", 32'(done), 32'h1);
      check("hold_stepcnt", 32'(step_cnt), 32'd3);
      tick();

      // Johnson up, 8 steps, start/mode noise mid-run, abort after 3 advances
      launch(1'b0, 1'b0, 8'd8);
      tick();
      check("abt_q1", 32'(q), 32'h1);
      start = 1'b1;
      mode  = 1'b1;
      steps = 8'd1;
      tick();
      check("abt_q2", 32'(q), 32'h3);
      start = 1'b0;
      tick();
      check("abt_q3", 32'(q), 32'h7);
      check("abt_busy3", 32'(busy), 32'h1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abt_q", 32'(q), 32'h0);
      check("abt_busy", 32'(busy), 32'h0);
      check("abt_done", 32'(done), 32'h0);
      check("abt_stepcnt", 32'(step_cnt), 32'd3);
      tick();
      check("abt_done_after", 32'(done), 32'h0);
      check("abt_q_idle", 32'(q), 32'h0);

      // Johnson down, 1 step, start asserted during DONE is ignored
      launch(1'b0, 1'b1, 8'd1);
      check("dn1_seed", 32'(q), 32'h0);
      tick();
      check("dn1_q", 32'(q), 32'h8);
      check("dn1_done", 32'(done), 32'h1);
      start = 1'b1;
      steps = 8'd4;
      tick();
      start = 1'b0;
      check("dn1_ign_q", 32'(q), 32'h8);
      check("dn1_ign_busy", 32'(busy), 32'h0);
      check("dn1_ign_done", 32'(done), 32'h0);
      check("dn1_ign_cnt", 32'(step_cnt), 32'd1);
      tick();
      check("dn1_idle_busy", 32'(busy), 32'h0);
      check("dn1_idle_q", 32'(q), 32'h8);

      // Asynchronous reset in the middle of RUN
      launch(1'b0, 1'b0, 8'd8);
      tick();
      tick();
      check("ar_q_pre", 32'(q), 32'h3);
      check("ar_cnt_pre", 32'(step_cnt), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check("ar_q", 32'(q), 32'h0);
      check("ar_busy", 32'(busy), 32'h0);
      check("ar_cnt", 32'(step_cnt), 32'h0);
      check("ar_done", 32'(done), 32'h0);
      #1;
      reset = 1'b1;
      tick();
      check("ar_idle_busy", 32'(busy), 32'h0);
      launch(1'b0, 1'b0, 8'd2);
      check("ar2_seed", 32'(q), 32'h0);
      check("ar2_busy", 32'(busy), 32'h1);
      tick();
      check("ar2_q1", 32'(q), 32'h1);
      check("ar2_nodone", 32'(done), 32'h0);
      tick();
      check("ar2_q2", 32'(q), 32'h3);
      check("ar2_done", 32'(done), 32'h1);
      check("ar2_cnt", 32'(step_cnt), 32'd2);
      tick();
      check("ar2_done_clr", 32'(done), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
